// File: rtl/weight_write_scheduler.sv
// Arbitrates the weight-memory write port: AXI writes always win, the boot-ROM init stream stalls.
// Latency: AXI writes and init writes appear on mem_wr_* one cycle after they win the port; the init data read is one cycle ahead of its write.
// Backpressure: AXI is never stalled; the init word is held while AXI occupies the port, and no further ROM read is issued.
module weight_write_scheduler #(
    parameter int NUM_WEIGHTS = 76976,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] axi_weight_data,
    input  logic [ADDR_WIDTH-1:0] axi_weight_addr,
    input  logic                  axi_weight_we,
    input  logic                  init_start,
    output logic                  init_rom_en,
    output logic [ADDR_WIDTH-1:0] init_rom_addr,
    input  logic [DATA_WIDTH-1:0] init_rom_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  init_busy,
    output logic                  init_done,
    output logic [15:0]           stall_cnt
);

    localparam logic [ADDR_WIDTH-1:0] NUM  = ADDR_WIDTH'(NUM_WEIGHTS);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WEIGHTS - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic                    v_rom;
    logic                    v_hold;
    logic [DATA_WIDTH-1:0]   hold_dat;

    logic                    run;
    logic                    v;
    logic                    consume;
    logic                    stall;
    logic [DATA_WIDTH-1:0]   init_dat;

    assign run      = (state == RUN);
    assign v        = v_rom | v_hold;
    assign consume  = run & v & ~axi_weight_we;
    assign stall    = run & v & axi_weight_we;
    assign init_dat = v_hold ? hold_dat : init_rom_data;

    // A new read is only issued when the current word leaves, so at most one word is ever in flight.
    assign init_rom_en   = run & (rd_ptr < NUM) & (~v | consume);
    assign init_rom_addr = rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            v_rom       <= 1'b0;
            v_hold      <= 1'b0;
            hold_dat    <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            init_busy   <= 1'b0;
            init_done   <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            mem_wr_en <= axi_weight_we | consume;
            if (axi_weight_we) begin
                mem_wr_addr <= axi_weight_addr;
                mem_wr_data <= axi_weight_data;
            end else if (consume) begin
                mem_wr_addr <= wr_ptr;
                mem_wr_data <= init_dat;
            end

            case (state)
                IDLE, DONE: begin
                    if (init_start) begin
                        state     <= RUN;
                        init_busy <= 1'b1;
                        init_done <= 1'b0;
                        rd_ptr    <= '0;
                        wr_ptr    <= '0;
                        v_rom     <= 1'b0;
                        v_hold    <= 1'b0;
                        stall_cnt <= '0;
                    end
                end
                RUN: begin
                    v_rom <= init_rom_en;
                    if (init_rom_en) begin
                        rd_ptr <= rd_ptr + ONE;
                    end
                    if (consume) begin
                        wr_ptr <= wr_ptr + ONE;
                        v_hold <= 1'b0;
                        if (wr_ptr == LAST) begin
                            state     <= DONE;
                            init_busy <= 1'b0;
                            init_done <= 1'b1;
                        end
                    end
                    if (stall) begin
                        // A word arriving from the ROM must be captured now; it is not presented again.
                        if (v_rom) begin
                            hold_dat <= init_rom_data;
                            v_hold   <= 1'b1;
                        end
                        if (stall_cnt != 16'hFFFF) begin
                            stall_cnt <= stall_cnt + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
